sgf_div_seq: RTL and testbench

//  Sequential radix-2 restoring divider for normalized FPU significands; the inverse datapath of the

---
 rtl/sgf_div_seq_pkg.sv | 27 ++
 rtl/sgf_div_step.sv | 23 ++
 rtl/sgf_div_seq.sv | 115 +++++++++++
 tb/tb_sgf_div_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sgf_div_seq_pkg.sv
// Shared definitions for the sequential significand divider: FSM states and width helpers.
package sgf_div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } div_state_t;

  localparam int unsigned SW_DEF = 24;
  localparam int unsigned QW     = SW_DEF + 2;
  localparam int unsigned RW     = SW_DEF + 1;
  localparam int unsigned CW     = $clog2(SW_DEF + 2);

  function automatic int unsigned sgf_qw(input int unsigned sw);
    return sw + 2;
  endfunction

  function automatic int unsigned sgf_rw(input int unsigned sw);
    return sw + 1;
  endfunction

  function automatic int unsigned sgf_cw(input int unsigned sw);
    return $clog2(sw + 2);
  endfunction

endpackage

// File: rtl/sgf_div_step.sv
// One combinational restoring-division step: trial subtract, quotient bit, restored and shifted remainder.
module sgf_div_step
  import sgf_div_seq_pkg::*;
#(
  parameter int unsigned SW = SW_DEF
) (
  input  logic [SW:0]   i_rem,
  input  logic [SW-1:0] i_div,
  output logic          o_q,
  output logic [SW:0]   o_rem_sel,
  output logic [SW:0]   o_rem_shl
);

  logic [SW+1:0] w_trial;

  // One extra bit above the remainder width so the sign bit selects restore.
  assign w_trial   = {1'b0, i_rem} - {2'b00, i_div};
  assign o_q       = ~w_trial[SW+1];
  assign o_rem_sel = o_q ? w_trial[SW:0] : i_rem;
  // The kept remainder is below the divisor, so its top bit is always zero here.
  assign o_rem_shl = {o_rem_sel[SW-1:0], 1'b0};

endmodule

// File: rtl/sgf_div_seq.sv
// Sequential radix-2 restoring divider for normalized significands, one quotient bit per clock.
module sgf_div_seq
  import sgf_div_seq_pkg::*;
#(
  parameter int unsigned SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [SW-1:0] Data_A_i,
  input  logic [SW-1:0] Data_B_i,
  output logic          ready_o,
  output logic          done_o,
  output logic [SW+1:0] quotient_o,
  output logic          sticky_o,
  output logic          div_zero_o
);

  localparam int unsigned Q_W = sgf_qw(SW);
  localparam int unsigned R_W = sgf_rw(SW);
  localparam int unsigned C_W = sgf_cw(SW);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [R_W-1:0]   r_rem;
  logic [SW-1:0]    r_div;
  logic [Q_W-1:0]   r_q;
  logic [C_W-1:0]   r_cnt;
  logic [Q_W-1:0]   r_quot;
  logic             r_sticky;
  logic             r_dz;

  logic             w_q;
  logic [R_W-1:0]   w_rem_sel;
  logic [R_W-1:0]   w_rem_shl;
  logic             w_b_zero;

  assign w_b_zero = (Data_B_i == '0);

  sgf_div_step #(.SW(SW)) u_step (
    .i_rem     (r_rem),
    .i_div     (r_div),
    .o_q       (w_q),
    .o_rem_sel (w_rem_sel),
    .o_rem_shl (w_rem_shl)
  );

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i) w_state_nxt = w_b_zero ? ST_FIN : ST_CALC;
      end
      ST_CALC: begin
        if (r_cnt == '0) w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rem    <= '0;
      r_div    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_sticky <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (w_b_zero) begin
              r_quot   <= '1;
              r_sticky <= 1'b0;
              r_dz     <= 1'b1;
            end else begin
              r_rem <= {1'b0, Data_A_i};
              r_div <= Data_B_i;
              r_q   <= '0;
              r_cnt <= C_W'(SW + 1);
              r_dz  <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_shl;
          r_q   <= {r_q[Q_W-2:0], w_q};
          if (r_cnt == '0) begin
            r_quot   <= {r_q[Q_W-2:0], w_q};
            r_sticky <= |w_rem_sel;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient_o = r_quot;
  assign sticky_o   = r_sticky;
  assign div_zero_o = r_dz;

endmodule

// File: tb/tb_sgf_div_seq.sv
// Directed and randomized checks of sgf_div_seq at SW=24 against hand values and a long-division model.
module tb_sgf_div_seq;

  localparam int SW = 24;
  localparam int QW = SW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [SW-1:0] Data_A_i;
  logic [SW-1:0] Data_B_i;
  logic          ready_o;
  logic          done_o;
  logic [QW-1:0] quotient_o;
  logic          sticky_o;
  logic          div_zero_o;

  int errors = 0;
  int checks = 0;

  logic [SW-1:0] dir_a [4] = '{24'h800000, 24'hC00000, 24'hFFFFFF, 24'h800000};
  logic [SW-1:0] dir_b [4] = '{24'h800000, 24'h800000, 24'h800000, 24'hC00000};
  logic [QW-1:0] dir_q [4] = '{26'h2000000, 26'h3000000, 26'h3FFFFFC, 26'h1555555};
  logic          dir_s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  sgf_div_seq #(.SW(SW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .Data_A_i   (Data_A_i),
    .Data_B_i   (Data_B_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .quotient_o (quotient_o),
    .sticky_o   (sticky_o),
    .div_zero_o (div_zero_o)
  );

  // Issues one op; lat is the cycle index (acceptance cycle = start) at which done_o is seen.
  task automatic run_op(input logic [SW-1:0] a, input logic [SW-1:0] b,
                        output int lat, output logic ok);
    @(negedge clk);
    Data_A_i = a;
    Data_B_i = b;
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; Data_A_i = '0; Data_B_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++; if (quotient_o !== '0) begin errors++; $display("FAIL reset_quot: got %h want 0", quotient_o); end
    checks++; if (sticky_o !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b want 0", sticky_o); end
    checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", div_zero_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed;
    int   lat;
    logic ok;
    for (int i = 0; i < 4; i++) begin
      run_op(dir_a[i], dir_b[i], lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dir%0d_timeout: no done_o within 40 cycles", i); end
      checks++; if (lat != SW + 3) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, SW + 3); end
      checks++; if (quotient_o !== dir_q[i]) begin errors++; $display("FAIL dir%0d_quot: got %h want %h", i, quotient_o, dir_q[i]); end
      checks++; if (sticky_o !== dir_s[i]) begin errors++; $display("FAIL dir%0d_sticky: got %b want %b", i, sticky_o, dir_s[i]); end
      checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL dir%0d_dz: got %b want 0", i, div_zero_o); end
      @(posedge clk); #1;
      checks++; if (done_o !== 1'b0 || ready_o !== 1'b1) begin
        errors++; $display("FAIL dir%0d_pulse: got done=%b ready=%b want done=0 ready=1", i, done_o, ready_o);
      end
    end
  endtask

  task automatic test_div_zero;
    int   lat;
    logic ok;
    run_op(24'h800000, 24'h000000, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dz_timeout: no done_o"); end
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
    checks++; if (quotient_o !== 26'h3FFFFFF) begin errors++; $display("FAIL dz_quot: got %h want 3ffffff", quotient_o); end
    checks++; if (sticky_o !== 1'b0) begin errors++; $display("FAIL dz_sticky: got %b want 0", sticky_o); end
    checks++; if (div_zero_o !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_zero_o); end
    @(posedge clk); #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL dz_pulse: got %b want 0", done_o); end
    // Valid op afterwards: flag clears at acceptance, quotient holds until completion.
    @(negedge clk);
    Data_A_i = 24'hC00000; Data_B_i = 24'h800000; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b want 0", div_zero_o); end
    checks++; if (quotient_o !== 26'h3FFFFFF) begin errors++; $display("FAIL dz_hold: got %h want 3ffffff", quotient_o); end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!ok || quotient_o !== 26'h3000000) begin
      errors++; $display("FAIL dz_next_quot: got %h done=%b want 3000000", quotient_o, ok);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int   lat;
    logic ok;
    @(negedge clk);
    Data_A_i = 24'h800000; Data_B_i = 24'h800000; start_i = 1'b1;
    @(posedge clk); #1;
    Data_A_i = 24'hC00000;
    lat = 1; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (!ok || lat != SW + 3) begin errors++; $display("FAIL b2b_first_latency: got %0d done=%b want %0d", lat, ok, SW + 3); end
    checks++; if (quotient_o !== 26'h2000000) begin errors++; $display("FAIL b2b_first_quot: got %h want 2000000", quotient_o); end
    @(posedge clk); #1;
    checks++; if (ready_o !== 1'b1 || done_o !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got ready=%b done=%b want ready=1 done=0", ready_o, done_o);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got ready=%b want 0", ready_o); end
    lat = 1; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (!ok || lat != SW + 3) begin errors++; $display("FAIL b2b_second_latency: got %0d done=%b want %0d", lat, ok, SW + 3); end
    checks++; if (quotient_o !== 26'h3000000) begin errors++; $display("FAIL b2b_second_quot: got %h want 3000000", quotient_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int seen_done;
    @(negedge clk);
    Data_A_i = 24'hFFFFFF; Data_B_i = 24'h800000; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ready_o); end
    checks++; if (quotient_o !== '0 || sticky_o !== 1'b0 || div_zero_o !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got q=%h s=%b dz=%b want 0", quotient_o, sticky_o, div_zero_o);
    end
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL midrst_no_done: got %0d done cycles want 0", seen_done); end
  endtask

  task automatic test_random;
    int              lat;
    logic            ok;
    logic [SW-1:0]   a;
    logic [SW-1:0]   b;
    longint unsigned num;
    logic [QW-1:0]   exp_q;
    logic            exp_s;
    for (int n = 0; n < 300; n++) begin
      a = SW'($urandom) | 24'h800000;
      b = SW'($urandom) | 24'h800000;
      num   = longint'(a) << (SW + 1);
      exp_q = QW'(num / longint'(b));
      exp_s = (num % longint'(b)) != 0;
      run_op(a, b, lat, ok);
      checks++; if (!ok || lat != SW + 3 || quotient_o !== exp_q || sticky_o !== exp_s) begin
        errors++;
        $display("FAIL rand%0d a=%h b=%h: got q=%h s=%b lat=%0d want q=%h s=%b lat=%0d",
                 n, a, b, quotient_o, sticky_o, lat, exp_q, exp_s, SW + 3);
      end
      @(posedge clk); #1;
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rand%0d_pulse: got %b want 0", n, done_o); end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
